// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a two-entry skid buffer, so in_ready is a register output.
// A synchronous flush either leaves a NOP bubble carrying in_side or empties the stage.
module pipe_stage_skid #(
  parameter int unsigned        INSTR_W      = 32,
  parameter int unsigned        SIDE_W       = 64,
  parameter logic [INSTR_W-1:0] NOP_VALUE    = {INSTR_W{1'b0}},
  parameter bit                 FLUSH_BUBBLE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [SIDE_W-1:0]  out_side,
  output logic [1:0]         occupancy
);

  logic               main_valid_q, main_valid_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [SIDE_W-1:0]  main_side_q,  main_side_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [SIDE_W-1:0]  skid_side_q,  skid_side_d;
  logic               accept;
  logic               pop;

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_instr = main_instr_q;
  assign out_side  = main_side_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  assign accept = in_valid & in_ready;
  assign pop    = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_side_d  = main_side_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_side_d  = skid_side_q;

    if (flush) begin
      // Flush wins over any accept/pop; the incoming word is discarded.
      skid_valid_d = 1'b0;
      skid_instr_d = NOP_VALUE;
      skid_side_d  = '0;
      main_instr_d = NOP_VALUE;
      if (FLUSH_BUBBLE) begin
        main_valid_d = 1'b1;
        main_side_d  = in_side;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      unique case ({main_valid_q, skid_valid_q})
        2'b00: begin
          if (accept) begin
            main_valid_d = 1'b1;
            main_instr_d = in_instr;
            main_side_d  = in_side;
          end
        end
        2'b10: begin
          if (accept && (pop || !main_valid_q)) begin
            main_instr_d = in_instr;
            main_side_d  = in_side;
          end else if (pop) begin
            main_valid_d = 1'b0;
          end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_instr_d = in_instr;
            skid_side_d  = in_side;
          end
        end
        2'b11: begin
          if (pop) begin
            main_instr_d = skid_instr_q;
            main_side_d  = skid_side_q;
            skid_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_instr_q <= NOP_VALUE;
      main_side_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_VALUE;
      skid_side_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_side_q  <= main_side_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_side_q  <= skid_side_d;
    end
  end

  // Skid may only hold data behind a valid main entry.
  a_skid_needs_main: assert property (@(posedge clk) disable iff (reset)
    !(skid_valid_q && !main_valid_q));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: one instance per flush mode, driven by shared stimulus.
module tb_pipe_stage_skid;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned SIDE_W  = 64;
  localparam logic [63:0] SideTag = 64'h1000_0000_0000_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic [SIDE_W-1:0]  in_side;
  logic               out_ready;

  logic               b_in_ready, b_out_valid;
  logic [INSTR_W-1:0] b_out_instr;
  logic [SIDE_W-1:0]  b_out_side;
  logic [1:0]         b_occ;
  logic               e_in_ready, e_out_valid;
  logic [INSTR_W-1:0] e_out_instr;
  logic [SIDE_W-1:0]  e_out_side;
  logic [1:0]         e_occ;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.INSTR_W(INSTR_W), .SIDE_W(SIDE_W), .FLUSH_BUBBLE(1'b1)) u_dut_bubble (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr), .in_side(in_side),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_instr(b_out_instr),
    .out_side(b_out_side), .occupancy(b_occ)
  );

  pipe_stage_skid #(.INSTR_W(INSTR_W), .SIDE_W(SIDE_W), .FLUSH_BUBBLE(1'b0)) u_dut_empty (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_instr(in_instr), .in_side(in_side),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_instr(e_out_instr),
    .out_side(e_out_side), .occupancy(e_occ)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Same expectation on both instances.
  task automatic check_both(input string tag, input int sel, input logic [63:0] exp);
    case (sel)
      0: begin check_eq({"b.valid ", tag}, 64'(b_out_valid), exp);
               check_eq({"e.valid ", tag}, 64'(e_out_valid), exp); end
      1: begin check_eq({"b.instr ", tag}, 64'(b_out_instr), exp);
               check_eq({"e.instr ", tag}, 64'(e_out_instr), exp); end
      2: begin check_eq({"b.occ ", tag}, 64'(b_occ), exp);
               check_eq({"e.occ ", tag}, 64'(e_occ), exp); end
      default: begin check_eq({"b.rdy ", tag}, 64'(b_in_ready), exp);
                     check_eq({"e.rdy ", tag}, 64'(e_in_ready), exp); end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [INSTR_W-1:0] instr);
    in_valid = v;
    in_instr = instr;
    in_side  = SideTag | 64'(instr);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    #2;
    check_both("reset", 0, 0);
    check_both("reset", 1, 0);
    check_both("reset", 2, 0);
    check_both("reset", 3, 1);
    check_eq("b.side reset", b_out_side, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, INSTR_W'(i));
      step();
      check_both($sformatf("stream%0d", i), 1, 64'(i));
      check_both($sformatf("stream%0d", i), 0, 1);
      check_both($sformatf("stream%0d", i), 2, 1);
      check_both($sformatf("stream%0d", i), 3, 1);
    end
    check_eq("b.side stream5", b_out_side, SideTag | 64'h5);
    drive(1'b0, '0);
    step();
    check_both("drain", 0, 0);
    check_both("drain", 2, 0);

    // Back-pressure: A in main, B in skid, C ignored until space.
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    step();
    check_both("bp A", 1, 64'hA);
    check_both("bp A", 2, 1);
    drive(1'b1, 32'hB);
    step();
    check_both("bp B", 2, 2);
    check_both("bp B", 3, 0);
    check_both("bp B", 1, 64'hA);
    drive(1'b1, 32'hC);
    step();
    check_both("bp C ign", 2, 2);
    check_both("bp C ign", 1, 64'hA);
    out_ready = 1'b1;
    step();
    check_both("bp pop A", 1, 64'hB);
    check_both("bp pop A", 2, 1);
    check_both("bp pop A", 3, 1);
    step();
    check_both("bp C", 1, 64'hC);
    check_both("bp C", 2, 1);
    drive(1'b0, '0);
    step();
    check_both("bp drain", 2, 0);

    // Flush with a full stage.
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    step();
    drive(1'b1, 32'hB);
    step();
    check_both("pre flush", 2, 2);
    drive(1'b0, '0);
    in_side = 64'h0000_0040_0000_0044;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("b.valid flush", 64'(b_out_valid), 1);
    check_eq("b.instr flush", 64'(b_out_instr), 0);
    check_eq("b.side flush", b_out_side, 64'h0000_0040_0000_0044);
    check_eq("b.occ flush", 64'(b_occ), 1);
    check_eq("e.valid flush", 64'(e_out_valid), 0);
    check_eq("e.instr flush", 64'(e_out_instr), 0);
    check_eq("e.side flush", e_out_side, SideTag | 64'hA);
    check_eq("e.occ flush", 64'(e_occ), 0);
    check_both("flush", 3, 1);
    out_ready = 1'b1;
    step();
    check_both("bubble pop", 2, 0);

    // Flush coinciding with accept and pop: 0xD must never surface.
    drive(1'b1, 32'h9);
    step();
    check_both("pre flush2", 1, 64'h9);
    drive(1'b1, 32'hD);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("b.valid flush2", 64'(b_out_valid), 1);
    check_eq("b.side flush2", b_out_side, SideTag | 64'hD);
    check_eq("b.occ flush2", 64'(b_occ), 1);
    check_eq("e.valid flush2", 64'(e_out_valid), 0);
    check_eq("e.occ flush2", 64'(e_occ), 0);
    check_both("flush2", 1, 0);
    drive(1'b0, '0);
    step();
    check_both("after flush2", 0, 0);
    check_both("after flush2", 1, 0);

    // Async reset between edges with a full stage.
    out_ready = 1'b0;
    drive(1'b1, 32'hA);
    step();
    drive(1'b1, 32'hB);
    step();
    check_both("pre reset", 2, 2);
    #2;
    reset = 1'b1;
    #1;
    check_both("async rst", 0, 0);
    check_both("async rst", 3, 1);
    check_both("async rst", 2, 0);
    check_both("async rst", 1, 0);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'hE);
    step();
    check_both("post rst", 1, 64'hE);
    check_both("post rst", 0, 1);
    drive(1'b0, '0);
    step();
    check_both("post rst drain", 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline stage register: the general replacement for fixed-width IF/ID-style registers.
- Carries an instruction field plus an opaque sideband field (PC, PC+4, etc.) between two pipeline stages using valid/ready.
- A 2-entry skid buffer (main + skid) keeps in_ready registered, so the stall path does not go combinationally from back to front.
- A synchronous flush either inserts a NOP bubble that still carries the incoming sideband, or empties the stage outright.

Parameters:
- INSTR_W, 32, width of instruction field.
- SIDE_W, 64, width of sideband field (e.g. {PC, PC+4}).
- NOP_VALUE, {INSTR_W{1'b0}}, instruction value used for bubbles and reset.
- FLUSH_BUBBLE, 1, 1: flush leaves a valid NOP bubble carrying in_side; 0: flush leaves the stage empty.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush, highest priority after reset.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept; equals ~skid_valid (pure register output).
- in_instr  input  INSTR_W  upstream instruction.
- in_side  input  SIDE_W  upstream sideband.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts.
- out_instr  output  INSTR_W  main entry instruction.
- out_side  output  SIDE_W  main entry sideband.
- occupancy  output  2  number of valid entries, 0..2.

Behaviour:
- Reset (async): main_valid=0, skid_valid=0, out_instr=NOP_VALUE, out_side=0, skid data=NOP_VALUE/0. Resulting outputs: in_ready=1, occupancy=0.
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- out_* always show the main entry. Skid data is never visible at the outputs.
- Latency: an accepted word appears on out_* the cycle after acceptance if main is empty or popping; otherwise it waits in skid.
- Ordering: strict FIFO; no word is dropped or duplicated without flush.
- Flush (overrides accept/pop that cycle):
  - Skid is cleared, so in_ready=1 next cycle.
  - FLUSH_BUBBLE=1: main_valid=1, out_instr=NOP_VALUE, out_side=in_side, regardless of in_valid. The bubble is a normal entry and must be popped.
  - FLUSH_BUBBLE=0: main_valid=0; out_instr=NOP_VALUE, out_side unchanged.
  - The in_* word on the flush cycle is never accepted as real data.
- State transitions without flush (M = main_valid, S = skid_valid):
  - M=0, S=0: accept -> main<=in, M=1. No accept -> hold.
  - M=1, S=0, pop & accept -> main<=in.
  - M=1, S=0, pop & no accept -> M=0, main data held.
  - M=1, S=0, no pop & accept -> skid<=in, S=1 (in_ready drops next cycle).
  - M=1, S=0, neither -> hold.
  - M=1, S=1 (in_ready=0, no accept): pop -> main<=skid, S=0. No pop -> hold all.
  - M=0, S=1 is unreachable; the assertion must fail if it occurs.
- Holding data: when not loading, entry registers keep value (no latch inference; all regs in clocked process with async reset).
- in_valid=1 while in_ready=0: ignored, no state change; upstream must hold the word.
- occupancy = M + S, registered-derived, updates with state.
- Reset asserted mid-transfer: all entries lost immediately (async). First accept is possible on the first clock edge after deassertion.

Test Plan:
- Reset then stream: in_valid=1, out_ready=1, instr 0x1..0x5 on consecutive cycles -> out_instr 0x1..0x5 one cycle later each, out_valid continuous, occupancy stays 1, in_ready stays 1.
- Back-pressure: out_ready=0 with main holding 0xA, accept 0xB -> occupancy=2, in_ready=0. Offer 0xC, which is ignored. out_ready=1 -> out 0xA then 0xB; 0xC accepted once in_ready=1.
- Flush bubble (FLUSH_BUBBLE=1): stage holding 0xA and 0xB, flush=1 with in_side=0x0000_0040_0000_0044 -> next cycle out_valid=1, out_instr=NOP_VALUE, out_side=0x0000_0040_0000_0044, occupancy=1, in_ready=1.
- Flush empty (FLUSH_BUBBLE=0): same stimulus -> out_valid=0, occupancy=0, out_instr=NOP_VALUE.
- Flush with simultaneous accept and pop: in_valid=1 (0xD), out_ready=1, flush=1 -> 0xD never appears at the outputs; the result matches the flush case for that parameter.
- Async reset mid-stream: assert reset between edges with occupancy=2 -> immediately out_valid=0, in_ready=1, occupancy=0, out_instr=NOP_VALUE. After release, the next accepted word emerges normally.
